// File: rtl/mtsp_mem_arbiter.sv
// mtsp_mem_arbiter
// Round-robin arbiter that shares the bus-master memory command port among
// PORTS requesters. One command at a time is captured, issued downstream as a
// single-cycle M_REQ pulse, and then the 256-bit beat stream is routed between
// the granted requester and the bus master until the beat count is exhausted.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   REQ_VALID/WE/ADDR/SIZE    per-port command inputs (port i in slice i)
//   REQ_ACK, REQ_DONE         per-port one-cycle capture / completion pulses
//   S_nIE, S_IDATA            per-port write data in (active-low present)
//   S_nIVALID                 per-port write beat consumed (active-low)
//   S_OE, S_ODATA             per-port read valid, broadcast read data
//   M_REQ/WE/ADDR/SIZE        downstream command
//   M_nIE, M_IDATA, M_nIVALID downstream write beat handshake
//   M_OE, M_ODATA             downstream read beats
//   GRANT_ID, ARB_BUSY        granted port, arbiter not idle
module mtsp_mem_arbiter #(
    parameter int PORTS  = 4,
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9,
    localparam int GW    = $clog2(PORTS)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [PORTS-1:0]        REQ_VALID,
    input  logic [PORTS-1:0]        REQ_WE,
    input  logic [PORTS*ADDR_W-1:0] REQ_ADDR,
    input  logic [PORTS*LEN_W-1:0]  REQ_SIZE,
    output logic [PORTS-1:0]        REQ_ACK,
    output logic [PORTS-1:0]        REQ_DONE,
    input  logic [PORTS-1:0]        S_nIE,
    input  logic [PORTS*256-1:0]    S_IDATA,
    output logic [PORTS-1:0]        S_nIVALID,
    output logic [PORTS-1:0]        S_OE,
    output logic [255:0]            S_ODATA,
    output logic                    M_REQ,
    output logic                    M_WE,
    output logic [ADDR_W-1:0]       M_ADDR,
    output logic [LEN_W-1:0]        M_SIZE,
    output logic                    M_nIE,
    output logic [255:0]            M_IDATA,
    input  logic                    M_nIVALID,
    input  logic                    M_OE,
    input  logic [255:0]            M_ODATA,
    output logic [GW-1:0]           GRANT_ID,
    output logic                    ARB_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [LEN_W-1:0]    m_size_q, m_size_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                found;
    logic                in_xfer;
    logic                sel_nie;
    logic                beat;

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % PORTS;
    endfunction

    assign in_xfer = (state_q == XFER);
    assign sel_nie = S_nIE[grant_q];
    // A beat only counts inside XFER and only on the handshake matching the
    // captured direction; stray downstream activity elsewhere is ignored.
    assign beat    = in_xfer & (m_we_q ? (~sel_nie & ~M_nIVALID) : M_OE);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        m_we_d   = m_we_q;
        m_addr_d = m_addr_q;
        m_size_d = m_size_q;
        cnt_d    = cnt_q;
        found    = 1'b0;
        case (state_q)
            IDLE: begin
                // First set request scanning upward from ptr, with wrap.
                for (int k = 0; k < PORTS; k++) begin
                    if (!found && REQ_VALID[wrap_idx(int'(ptr_q), k)]) begin
                        found    = 1'b1;
                        grant_d  = GW'(wrap_idx(int'(ptr_q), k));
                        m_we_d   = REQ_WE[wrap_idx(int'(ptr_q), k)];
                        m_addr_d = REQ_ADDR[wrap_idx(int'(ptr_q), k)*ADDR_W +: ADDR_W];
                        m_size_d = REQ_SIZE[wrap_idx(int'(ptr_q), k)*LEN_W +: LEN_W];
                    end
                end
                if (found) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A zero-length command still moves one beat.
                cnt_d   = (m_size_q == '0) ? LEN_W'(1) : m_size_q;
                state_d = XFER;
            end
            XFER: begin
                if (beat) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ptr_d   = (grant_q == GW'(PORTS - 1)) ? '0 : grant_q + GW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_size_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            m_we_q   <= m_we_d;
            m_addr_q <= m_addr_d;
            m_size_q <= m_size_d;
            cnt_q    <= cnt_d;
        end
    end

    assign M_REQ    = (state_q == ISSUE);
    assign M_WE     = m_we_q;
    assign M_ADDR   = m_addr_q;
    assign M_SIZE   = m_size_q;
    assign GRANT_ID = grant_q;
    assign ARB_BUSY = (state_q != IDLE);
    assign M_nIE    = (in_xfer & m_we_q) ? sel_nie : 1'b1;
    assign M_IDATA  = S_IDATA[int'(grant_q)*256 +: 256];
    assign S_ODATA  = M_ODATA;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            logic is_grant;
            assign is_grant      = (grant_q == GW'(gi));
            assign REQ_ACK[gi]   = (state_q == ISSUE) & is_grant;
            assign REQ_DONE[gi]  = (state_q == DONE) & is_grant;
            assign S_OE[gi]      = in_xfer & ~m_we_q & is_grant & M_OE;
            assign S_nIVALID[gi] = ~(in_xfer & m_we_q & is_grant & ~M_nIVALID);
        end
    endgenerate

endmodule

// File: doc/mtsp_mem_arbiter.md
# mtsp_mem_arbiter

Round-robin arbiter that shares the single MTSP bus-master memory command port among `PORTS` processor-side requesters. It captures one command at a time and issues it downstream as a one-cycle `M_REQ` pulse. It then routes the 256-bit read or write beat stream between the granted requester and the bus master, and counts beats to detect completion. It sits between the per-core memory command sources and the bus-master block.

## Interface
Parameters:
- `PORTS`, 4: number of requesters (2..8).
- `ADDR_W`, 24: paddr width in 16-byte units; downstream forms `{4'h8, paddr, 4'b0}`.
- `LEN_W`, 9: transfer length field, in 256-bit beats.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `REQ_VALID`  in  PORTS  per-port command request; held until `REQ_ACK`.
- `REQ_WE`  in  PORTS  1 = write, 0 = read.
- `REQ_ADDR`  in  PORTS*ADDR_W  per-port paddr; port i occupies slice i.
- `REQ_SIZE`  in  PORTS*LEN_W  per-port beat count.
- `REQ_ACK`  out  PORTS  one-cycle pulse: command captured.
- `REQ_DONE`  out  PORTS  one-cycle pulse: last beat transferred.
- `S_nIE`  in  PORTS  write data present, active-low.
- `S_IDATA`  in  PORTS*256  write data.
- `S_nIVALID`  out  PORTS  write beat consumed, active-low.
- `S_OE`  out  PORTS  read beat valid.
- `S_ODATA`  out  256  read data, broadcast to all ports.
- `M_REQ`  out  1  downstream command pulse.
- `M_WE`  out  1  command direction.
- `M_ADDR`  out  ADDR_W  command address.
- `M_SIZE`  out  LEN_W  command length.
- `M_nIE`  out  1  write data present, active-low.
- `M_IDATA`  out  256  write data.
- `M_nIVALID`  in  1  write beat accepted, active-low.
- `M_OE`  in  1  read beat valid.
- `M_ODATA`  in  256  read data.
- `GRANT_ID`  out  clog2(PORTS)  currently granted port.
- `ARB_BUSY`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, XFER, DONE.
- **IDLE:**
  - If any `REQ_VALID` is set, select the first set bit scanning from `ptr` upward with wrap.
  - Register the winner's `WE`, `ADDR` and `SIZE` into `M_WE`, `M_ADDR` and `M_SIZE`, and the winner's index into `GRANT_ID`.
  - Go to ISSUE.
- **ISSUE:**
  - `M_REQ`=1 and `REQ_ACK[GRANT_ID]`=1, both for exactly this cycle.
  - Load `cnt` = `M_SIZE`; a size of 0 loads 1.
  - Go to XFER.
- **XFER, read:**
  - Each cycle with `M_OE`=1 asserts `S_OE[GRANT_ID]` and decrements `cnt`.
- **XFER, write:**
  - `M_nIE` = `S_nIE[GRANT_ID]` and `M_IDATA` = `S_IDATA[GRANT_ID]`.
  - `S_nIVALID[GRANT_ID]` = `M_nIVALID`.
  - Each cycle with `M_nIE`=0 and `M_nIVALID`=0 decrements `cnt`.
- **XFER exit:** the beat that decrements `cnt` from 1 to 0 moves the FSM to DONE.
- **DONE:**
  - `REQ_DONE[GRANT_ID]`=1 for one cycle.
  - `ptr` = `GRANT_ID`+1, modulo `PORTS`.
  - Go to IDLE.
- **Data routing:**
  - Routing is combinational from `GRANT_ID` and state.
  - Non-granted ports see `S_OE`=0 and `S_nIVALID`=1.
  - Outside XFER: `M_nIE`=1, all `S_OE`=0, all `S_nIVALID`=1.
  - `M_OE` or `M_nIVALID` activity outside XFER is ignored and never decrements `cnt`.
- **Width rules:** `cnt` is `LEN_W` bits and never underflows, because XFER exits at 0.
- **Reset values:**
  - `M_REQ`, `M_WE`, `M_ADDR`, `M_SIZE`, `GRANT_ID`, `REQ_ACK`, `REQ_DONE`, `S_OE`, `ARB_BUSY` = 0.
  - `M_nIE`, `S_nIVALID` = all 1.
  - `ptr` = 0; state = IDLE; `cnt` = 0.
- **Reset mid-transaction:** abandon immediately with no `REQ_DONE`; downstream beats arriving after reset are ignored.
- **Simultaneous events:**
  - New `REQ_VALID` during ISSUE, XFER or DONE is not sampled; it waits for IDLE.
  - A requester dropping `REQ_VALID` after capture does not cancel the command.

## Timing
- `REQ_VALID` sampled high in IDLE at cycle t → `M_REQ`, `REQ_ACK` and `GRANT_ID` valid at t+1.
- First beat may be counted at t+2.
- `REQ_DONE` occurs one cycle after the last beat.
- IDLE follows one cycle after DONE; the next `M_REQ` comes no earlier than 2 cycles after DONE.
- Minimum occupancy for a 1-beat transfer with an immediate beat: 4 cycles (IDLE, ISSUE, XFER, DONE).
- Requesters must deassert `REQ_VALID` the cycle after seeing `REQ_ACK`, or the command is re-arbitrated as a new request.

## Test plan
- **Single read:** port 2 reads addr 0x001234, size 4, with `M_OE` on 4 consecutive cycles → one `M_REQ` with `M_ADDR`=0x001234, `M_WE`=0, `M_SIZE`=4; `S_OE[2]` pulses 4 times; `REQ_DONE[2]` one cycle after the 4th beat.
- **Write with stalls:** port 1 writes size 3; `M_nIVALID` toggles 1,0,1,0,0 → exactly 3 accepted beats; `S_nIVALID[1]` mirrors them; `S_nIVALID[0,2,3]` stay 1.
- **Round-robin fairness:** all 4 ports request continuously with size 1 → grant order 0,1,2,3,0; each port receives one `REQ_ACK` per round.
- **Size 0 and stray beats:** size 0 → treated as 1 beat; `M_OE` pulses while in IDLE → no `S_OE`, no state change.
- **Reset mid-XFER:** `nRST` low for 1 cycle after 2 of 8 beats → all outputs at reset values next cycle, no `REQ_DONE`; a subsequent request from port 3 is granted first because `ptr`=0 and it is the only requester.
